// File: rtl/prim_ram_1p_initiator_if.sv
// Command, read-response and RAM-side signals of prim_ram_1p_initiator.
// The slave modport is the initiator's view; master is the environment's view.
interface prim_ram_1p_initiator_if #(
  parameter int Width = 32,
  parameter int Depth = 128
);
  localparam int Aw = $clog2(Depth);

  // command channel
  logic             cmd_valid_i;
  logic             cmd_ready_o;
  logic             cmd_write_i;
  logic [Aw-1:0]    cmd_addr_i;
  logic [Width-1:0] cmd_wdata_i;
  logic [Width-1:0] cmd_wmask_i;

  // read-response channel
  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic [Width-1:0] rsp_rdata_o;

  // single-port RAM, one cycle read latency
  logic             ram_req_o;
  logic             ram_write_o;
  logic [Aw-1:0]    ram_addr_o;
  logic [Width-1:0] ram_wdata_o;
  logic [Width-1:0] ram_wmask_o;
  logic             ram_rvalid_i;
  logic [Width-1:0] ram_rdata_i;

  // status
  logic             busy_o;
  logic             err_o;

  modport slave (
    input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_wmask_i,
    output cmd_ready_o,
    output rsp_valid_o, rsp_rdata_o,
    input  rsp_ready_i,
    output ram_req_o, ram_write_o, ram_addr_o, ram_wdata_o, ram_wmask_o,
    input  ram_rvalid_i, ram_rdata_i,
    output busy_o, err_o
  );

  modport master (
    output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_wmask_i,
    input  cmd_ready_o,
    input  rsp_valid_o, rsp_rdata_o,
    output rsp_ready_i,
    input  ram_req_o, ram_write_o, ram_addr_o, ram_wdata_o, ram_wmask_o,
    output ram_rvalid_i, ram_rdata_i,
    input  busy_o, err_o
  );
endinterface

// File: rtl/prim_ram_1p_initiator.sv
// Single-port RAM initiator: forwards commands to a 1-cycle-latency RAM,
// tracks one outstanding read and buffers read data in a credit-protected
// response FIFO so responses leave in command order.
// Optional macro PRIM_RAM_1P_INIT_CLEAR_EN: after reset, sweep all Depth
// words to zero before accepting commands (busy_o high during the sweep).
module prim_ram_1p_initiator #(
  parameter int Width    = 32,
  parameter int Depth    = 128,
  parameter int RspDepth = 4
) (
  input logic                   clk_i,
  input logic                   rst_i,
  prim_ram_1p_initiator_if.slave bus
);
  localparam int Aw = $clog2(Depth);
  localparam int CW = $clog2(RspDepth + 1);
  localparam int PW = $clog2(RspDepth);

  logic             cmd_ready;
  logic             accept_rd;
  logic             credit_ok;
  logic [CW:0]      credit_used;
  logic             in_init;

  logic             inflight_q;
  logic             err_q;
  logic [CW-1:0]    fifo_count_q;
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [Width-1:0] fifo_mem [RspDepth];

  logic             push;
  logic             pop;
  logic             rsp_valid;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(RspDepth - 1)) return '0;
    else return p + PW'(1);
  endfunction

`ifdef PRIM_RAM_1P_INIT_CLEAR_EN
  typedef enum logic {ST_INIT, ST_RUN} state_e;
  state_e        state_q, state_d;
  logic [Aw-1:0] init_addr_q, init_addr_d;

  // state register and sweep address counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_INIT;
      init_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
    end
  end

  // sweep advances one word per cycle and hands over to RUN after the last word
  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    if (state_q == ST_INIT) begin
      init_addr_d = init_addr_q + Aw'(1);
      if (init_addr_q == Aw'(Depth - 1)) begin
        state_d     = ST_RUN;
        init_addr_d = '0;
      end
    end
  end

  assign in_init    = (state_q == ST_INIT);
  assign bus.busy_o = in_init;
`else
  assign in_init    = 1'b0;
  assign bus.busy_o = 1'b0;
`endif

  // outstanding read plus buffered responses must fit in the FIFO
  assign credit_used = {1'b0, fifo_count_q} + {{CW{1'b0}}, inflight_q};
  assign credit_ok   = credit_used < (CW+1)'(RspDepth);

  // command acceptance and RAM request steering
  always_comb begin
    cmd_ready       = 1'b0;
    bus.ram_req_o   = 1'b0;
    bus.ram_write_o = 1'b0;
    bus.ram_addr_o  = bus.cmd_addr_i;
    bus.ram_wdata_o = bus.cmd_wdata_i;
    bus.ram_wmask_o = bus.cmd_wmask_i;
    if (!rst_i) begin
      if (in_init) begin
        bus.ram_req_o   = 1'b1;
        bus.ram_write_o = 1'b1;
`ifdef PRIM_RAM_1P_INIT_CLEAR_EN
        bus.ram_addr_o  = init_addr_q;
`endif
        bus.ram_wdata_o = '0;
        bus.ram_wmask_o = '1;
      end else begin
        cmd_ready = bus.cmd_write_i | credit_ok;
        if (bus.cmd_valid_i && cmd_ready) begin
          bus.ram_req_o   = 1'b1;
          bus.ram_write_o = bus.cmd_write_i;
        end
      end
    end
  end

  assign accept_rd       = bus.cmd_valid_i & cmd_ready & ~bus.cmd_write_i;
  assign bus.cmd_ready_o = cmd_ready;

  assign push      = ~rst_i & bus.ram_rvalid_i & inflight_q;
  assign rsp_valid = ~rst_i & (fifo_count_q != '0);
  assign pop       = rsp_valid & bus.rsp_ready_i;

  // control state: in-flight flag, sticky error, FIFO pointers and count
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inflight_q   <= 1'b0;
      err_q        <= 1'b0;
      fifo_count_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      if (accept_rd)             inflight_q <= 1'b1;
      else if (bus.ram_rvalid_i) inflight_q <= 1'b0;
      if (bus.ram_rvalid_i && !inflight_q) err_q <= 1'b1;
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   fifo_count_q <= fifo_count_q + CW'(1);
        2'b01:   fifo_count_q <= fifo_count_q - CW'(1);
        default: fifo_count_q <= fifo_count_q;
      endcase
    end
  end

  // response data storage
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q] <= bus.ram_rdata_i;
  end

  assign bus.rsp_valid_o = rsp_valid;
  assign bus.rsp_rdata_o = fifo_mem[rd_ptr_q];
  assign bus.err_o       = err_q;
endmodule
